// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Iterates on operand magnitudes, one quotient bit per cycle, then applies sign fix-up.
// Returns {remainder, quotient} for the HI/LO write path with a one-cycle ready pulse.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               stall_div,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Busy = 2'd1,
    Done = 2'd2
  } stateT;

  stateT            state;
  logic [CntW-1:0]  cnt;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divMag;
  logic             signQ;
  logic             signR;

  // Operand signs and magnitudes; DIVU treats both operands as unsigned.
  logic             negA;
  logic             negB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;

  assign negA = signed_div & opa[WIDTH-1];
  assign negB = signed_div & opb[WIDTH-1];
  assign magA = negA ? (-opa) : opa;
  assign magB = negB ? (-opb) : opb;

  // One restoring step: shift {r,q} left, subtract |b| when it fits.
  logic [WIDTH:0]   shiftRem;
  logic [WIDTH-1:0] diffLow;
  logic             noBorrow;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] nextQuo;

  assign shiftRem = {remReg, quoReg[WIDTH-1]};
  assign noBorrow = (shiftRem >= {1'b0, divMag});
  // When the subtraction fits, the true difference is below |b| and fits in WIDTH bits.
  assign diffLow  = shiftRem[WIDTH-1:0] - divMag;
  assign nextRem  = noBorrow ? diffLow : shiftRem[WIDTH-1:0];
  assign nextQuo  = {quoReg[WIDTH-2:0], noBorrow};

  // Sign fix-up applied to the final step's outputs as DONE is entered.
  logic [WIDTH-1:0] fixQuo;
  logic [WIDTH-1:0] fixRem;

  assign fixQuo = signQ ? (-nextQuo) : nextQuo;
  assign fixRem = signR ? (-nextRem) : nextRem;

  // Pipeline hold: accepted request in IDLE or iterating; forced low during reset.
  assign stall_div = rst & (((state == Idle) & start & ~annul) | (state == Busy));

  // Control FSM, datapath registers and registered result/ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= Idle;
      cnt    <= '0;
      remReg <= '0;
      quoReg <= '0;
      divMag <= '0;
      signQ  <= 1'b0;
      signR  <= 1'b0;
      ready  <= 1'b0;
      result <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        Idle: begin
          if (start && !annul) begin
            remReg <= '0;
            quoReg <= magA;
            divMag <= magB;
            signQ  <= negA ^ negB;
            signR  <= negA;
            cnt    <= '0;
            if (opb == '0) begin
              // Zero divisor: skip iteration, return raw dividend and all-ones quotient.
              state  <= Done;
              ready  <= 1'b1;
              result <= {opa, {WIDTH{1'b1}}};
            end else begin
              state <= Busy;
            end
          end
        end
        Busy: begin
          if (annul) begin
            state <= Idle;
            cnt   <= '0;
          end else begin
            remReg <= nextRem;
            quoReg <= nextQuo;
            cnt    <= cnt + CntW'(1);
            if (cnt == LastCnt) begin
              state  <= Done;
              ready  <= 1'b1;
              result <= {fixRem, fixQuo};
            end
          end
        end
        Done: begin
          state <= Idle;
        end
        default: begin
          state <= Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected {rem,quo} per request.
module tb_div_unit;

  localparam int unsigned W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_div;
  logic           annul;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic           stall_div;
  logic           ready;
  logic [2*W-1:0] result;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] expQ[$];
  logic [2*W-1:0] lastResult;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_div(signed_div),
    .annul     (annul),
    .opa       (opa),
    .opb       (opb),
    .stall_div (stall_div),
    .ready     (ready),
    .result    (result)
  );

  // Reference division using 64-bit arithmetic (truncating, remainder follows dividend).
  function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one request in the current (low) clock phase and follow it to ready.
  task automatic runOp(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, output int lat, output int stallCnt,
                       output logic stallAtReady, output logic [63:0] got,
                       output logic seen, output logic readyAfter);
    start = 1'b1;
    signed_div = sgn;
    opa = a;
    opb = b;
    annul = 1'b0;
    expQ.push_back(exp);
    #1;
    stallCnt = stall_div ? 1 : 0;
    @(negedge clk);
    start = 1'b0;
    signed_div = ~sgn;
    opa = $urandom;
    opb = $urandom;
    lat = 1;
    seen = 1'b0;
    while (lat < 200) begin
      #1;
      if (ready) begin
        seen = 1'b1;
        break;
      end
      if (stall_div) stallCnt++;
      @(negedge clk);
      lat++;
    end
    stallAtReady = stall_div;
    got = result;
    @(negedge clk);
    #1;
    readyAfter = ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    signed_div = 1'b0;
    annul = 1'b0;
    opa = '0;
    opb = '0;
    #2 rst = 1'b0;
    start = 1'b1;
    opa = 32'd5;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (stall_div !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_div); end
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (stall_div !== 1'b0 || ready !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle stall=%b ready=%b exp=0/0", stall_div, ready);
    end
    lastResult = 64'd0;
  endtask

  task automatic test_divu();
    int lat, sc;
    logic sar, seen, ra;
    logic [63:0] got, exp;
    runOp(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, lat, sc, sar, got, seen, ra);
    exp = expQ.pop_front();
    checks++; if (!seen || got !== exp) begin failures++; $display("FAIL divu_100_7 got=%h exp=%h seen=%b", got, exp, seen); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    checks++; if (sc !== 33) begin failures++; $display("FAIL divu_stall_cycles got=%0d exp=33", sc); end
    checks++; if (sar !== 1'b0) begin failures++; $display("FAIL divu_stall_at_ready got=%b exp=0", sar); end
    checks++; if (ra !== 1'b0) begin failures++; $display("FAIL divu_ready_pulse got=%b exp=0", ra); end
    checks++; if (result !== exp) begin failures++; $display("FAIL divu_result_hold got=%h exp=%h", result, exp); end
    lastResult = exp;
  endtask

  task automatic test_signed();
    int lat, sc;
    logic sar, seen, ra, sgn;
    logic [31:0] a, b;
    logic [63:0] got, exp;
    runOp(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, lat, sc, sar, got, seen, ra);
    exp = expQ.pop_front();
    checks++; if (!seen || got !== exp) begin failures++; $display("FAIL div_m7_2 got=%h exp=%h", got, exp); end
    runOp(1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, lat, sc, sar, got, seen, ra);
    exp = expQ.pop_front();
    checks++; if (!seen || got !== exp) begin failures++; $display("FAIL div_7_m2 got=%h exp=%h", got, exp); end
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = (i < 3) ? ($urandom & 32'h0000FFFF) : $urandom;
      if (b == 32'd0) b = 32'd3;
      sgn = (i % 2 == 0);
      runOp(sgn, a, b, refDiv(sgn, a, b), lat, sc, sar, got, seen, ra);
      exp = expQ.pop_front();
      checks++; if (!seen || got !== exp || lat !== 33) begin
        failures++; $display("FAIL random_%0d sgn=%b a=%h b=%h got=%h exp=%h lat=%0d", i, sgn, a, b, got, exp, lat);
      end
    end
    lastResult = exp;
  endtask

  task automatic test_overflow();
    int lat, sc;
    logic sar, seen, ra;
    logic [63:0] got, exp;
    runOp(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, lat, sc, sar, got, seen, ra);
    exp = expQ.pop_front();
    checks++; if (!seen || got !== exp) begin failures++; $display("FAIL div_overflow got=%h exp=%h", got, exp); end
    runOp(1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, lat, sc, sar, got, seen, ra);
    exp = expQ.pop_front();
    checks++; if (!seen || got !== exp) begin failures++; $display("FAIL divu_max_by_1 got=%h exp=%h", got, exp); end
    lastResult = exp;
  endtask

  task automatic test_zero_div();
    int lat, sc;
    logic sar, seen, ra;
    logic [63:0] got, exp;
    runOp(1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, lat, sc, sar, got, seen, ra);
    exp = expQ.pop_front();
    checks++; if (!seen || got !== exp) begin failures++; $display("FAIL zero_div_result got=%h exp=%h", got, exp); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL zero_div_latency got=%0d exp=1", lat); end
    checks++; if (sc !== 1) begin failures++; $display("FAIL zero_div_stall_cycles got=%0d exp=1", sc); end
    checks++; if (sar !== 1'b0 || ra !== 1'b0) begin
      failures++; $display("FAIL zero_div_pulse stall_at_ready=%b ready_after=%b exp=0/0", sar, ra);
    end
    lastResult = exp;
  endtask

  task automatic test_annul();
    int lat, sc;
    logic sar, seen, ra, sawReady;
    logic [63:0] got, exp;
    // Abandon an operation mid-iteration.
    start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3; annul = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    #1;
    checks++; if (stall_div !== 1'b0) begin failures++; $display("FAIL annul_idle_stall got=%b exp=0", stall_div); end
    sawReady = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (ready) sawReady = 1'b1;
    end
    checks++; if (sawReady !== 1'b0) begin failures++; $display("FAIL annul_no_ready got=%b exp=0", sawReady); end
    checks++; if (result !== lastResult) begin failures++; $display("FAIL annul_result_kept got=%h exp=%h", result, lastResult); end
    // Start together with annul in IDLE is ignored.
    start = 1'b1; opa = 32'd50; opb = 32'd5; annul = 1'b1;
    #1;
    checks++; if (stall_div !== 1'b0) begin failures++; $display("FAIL start_annul_stall got=%b exp=0", stall_div); end
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    sawReady = 1'b0;
    repeat (3) begin
      #1;
      if (ready || stall_div) sawReady = 1'b1;
      @(negedge clk);
    end
    checks++; if (sawReady !== 1'b0) begin failures++; $display("FAIL start_annul_ignored got=%b exp=0", sawReady); end
    // A second start during BUSY is ignored.
    start = 1'b1; signed_div = 1'b0; opa = 32'd1000; opb = 32'd3;
    expQ.push_back({32'd1, 32'd333});
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    start = 1'b1; opa = 32'd50; opb = 32'd5;
    @(negedge clk);
    start = 1'b0;
    lat++;
    seen = 1'b0;
    while (lat < 200) begin
      #1;
      if (ready) begin seen = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
    got = result;
    exp = expQ.pop_front();
    checks++; if (!seen || got !== exp || lat !== 33) begin
      failures++; $display("FAIL busy_start_ignored got=%h exp=%h lat=%0d", got, exp, lat);
    end
    sawReady = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (ready) sawReady = 1'b1;
    end
    checks++; if (sawReady !== 1'b0) begin failures++; $display("FAIL busy_start_not_queued got=%b exp=0", sawReady); end
    // Fresh request after returning to IDLE.
    runOp(1'b0, 32'd77, 32'd7, {32'd0, 32'd11}, lat, sc, sar, got, seen, ra);
    exp = expQ.pop_front();
    checks++; if (!seen || got !== exp || lat !== 33) begin
      failures++; $display("FAIL after_annul got=%h exp=%h lat=%0d", got, exp, lat);
    end
    lastResult = exp;
  endtask

  task automatic test_back_to_back();
    int lat, sc;
    logic sar, seen, ra;
    logic [63:0] got, exp;
    runOp(1'b1, 32'hFFFFFF9C, 32'd9, {32'hFFFFFFFF, 32'hFFFFFFF5}, lat, sc, sar, got, seen, ra);
    exp = expQ.pop_front();
    checks++; if (!seen || got !== exp) begin failures++; $display("FAIL b2b_first got=%h exp=%h", got, exp); end
    runOp(1'b0, 32'd1234567, 32'd1000, {32'd567, 32'd1234}, lat, sc, sar, got, seen, ra);
    exp = expQ.pop_front();
    checks++; if (!seen || got !== exp || lat !== 33 || sc !== 33) begin
      failures++; $display("FAIL b2b_second got=%h exp=%h lat=%0d stall=%0d", got, exp, lat, sc);
    end
    lastResult = exp;
  endtask

  task automatic test_async_reset();
    int lat, sc;
    logic sar, seen, ra;
    logic [63:0] got, exp;
    start = 1'b1; signed_div = 1'b0; opa = 32'd123456; opb = 32'd10; annul = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (stall_div !== 1'b0 || ready !== 1'b0) begin
      failures++; $display("FAIL async_reset_ctrl stall=%b ready=%b exp=0/0", stall_div, ready);
    end
    checks++; if (result !== 64'd0) begin failures++; $display("FAIL async_reset_result got=%h exp=0", result); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    runOp(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, lat, sc, sar, got, seen, ra);
    exp = expQ.pop_front();
    checks++; if (!seen || got !== exp || lat !== 33) begin
      failures++; $display("FAIL after_async_reset got=%h exp=%h lat=%0d", got, exp, lat);
    end
    lastResult = exp;
  endtask

  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_overflow();
    test_zero_div();
    test_annul();
    test_back_to_back();
    test_async_reset();
    checks++; if (expQ.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", expQ.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
